// File: rtl/demux_dispatch_ctrl_if.sv
// Handshake bundle between the producer, the dispatch
// controller and the eight demux consumers.
interface demux_dispatch_ctrl_if #(
   parameter int DW = 8
);
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic [2:0]    in_dest;
   logic          mode;
   logic [7:0]    en_mask;
   logic          in_ready;
   logic [2:0]    sel;
   logic [DW-1:0] out_data;
   logic [7:0]    out_valid;
   logic [7:0]    out_ready;

   modport master (
      output in_valid, in_data, in_dest,
      output mode, en_mask, out_ready,
      input  in_ready, sel, out_data, out_valid
   );

   modport slave (
      input  in_valid, in_data, in_dest,
      input  mode, en_mask, out_ready,
      output in_ready, sel, out_data, out_valid
   );
endinterface

// File: rtl/demux_dispatch_ctrl.sv
// Single-entry dispatch controller for the 1-to-8 demux:
// addressed or round-robin routing, hold until ready or timeout.
module demux_dispatch_ctrl #(
   parameter int DW      = 8,
   parameter int TIMEOUT = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   demux_dispatch_ctrl_if.slave    bus,
   output logic                    err,
   output logic [15:0]             xfer_cnt,
   output logic [7:0]              drop_cnt
);
   localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [2:0]    sel_q, sel_d;
   logic [DW-1:0] data_q, data_d;
   logic [WW-1:0] wait_q, wait_d;
   logic [2:0]    last_rr_q, last_rr_d;
   logic          err_q, err_d;
   logic [15:0]   xfer_q, xfer_d;
   logic [7:0]    drop_q, drop_d;

   logic [2:0]    rr_idx;
   logic [2:0]    rr_cand;
   logic          rr_hit;
   logic          rdy;
   logic          accept;

   // Circular search upward from the slot after last_rr.
   always_comb begin
      rr_idx  = last_rr_q;
      rr_cand = last_rr_q;
      rr_hit  = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         rr_cand = last_rr_q + 3'(i);
         if (!rr_hit && bus.en_mask[rr_cand]) begin
            rr_idx = rr_cand;
            rr_hit = 1'b1;
         end
      end
   end

   // Handshake outputs decoded from registered state.
   always_comb begin
      rdy = !(bus.mode && (bus.en_mask == 8'h00));
      bus.in_ready  = (state_q == IDLE) && rdy;
      bus.sel       = sel_q;
      bus.out_data  = data_q;
      bus.out_valid = (state_q == HOLD) ? (8'b1 << sel_q)
                                        : 8'h00;
      accept = bus.in_valid && bus.in_ready;
   end

   // Next-state: accept, transfer, or timeout drop.
   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      data_d    = data_q;
      wait_d    = wait_q;
      last_rr_d = last_rr_q;
      err_d     = 1'b0;
      xfer_d    = xfer_q;
      drop_d    = drop_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               data_d  = bus.in_data;
               wait_d  = '0;
               state_d = HOLD;
               if (bus.mode) begin
                  sel_d     = rr_idx;
                  last_rr_d = rr_idx;
               end else begin
                  sel_d = bus.in_dest;
               end
            end
         end
         HOLD: begin
            if (bus.out_ready[sel_q]) begin
               xfer_d  = xfer_q + 16'd1;
               state_d = IDLE;
            end else if (wait_q == WW'(TIMEOUT-1)) begin
               err_d   = 1'b1;
               state_d = IDLE;
               if (drop_q != 8'hFF)
                  drop_d = drop_q + 8'd1;
            end else begin
               wait_d = wait_q + WW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         sel_q     <= 3'd0;
         data_q    <= '0;
         wait_q    <= '0;
         last_rr_q <= 3'd7;
         err_q     <= 1'b0;
         xfer_q    <= 16'd0;
         drop_q    <= 8'd0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         data_q    <= data_d;
         wait_q    <= wait_d;
         last_rr_q <= last_rr_d;
         err_q     <= err_d;
         xfer_q    <= xfer_d;
         drop_q    <= drop_d;
      end
   end

   assign err      = err_q;
   assign xfer_cnt = xfer_q;
   assign drop_cnt = drop_q;
endmodule
